shift_left_32bit: RTL and testbench
===================================

SHIFT_LEFT_32BIT -- requirements
Module: shift_left_32bit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; equals log2(DATA_W).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  qualifies i and shamt in the current cycle.
REQ-006 i  input  32  operand to be shifted.
REQ-007 shamt  input  5  unsigned shift amount, 0..31.
REQ-008 r  output  32  registered result, i shifted left by shamt.
REQ-009 out_valid  output  1  high for exactly the cycle in which r holds a freshly computed result.

Function
REQ-010 Logical left shift: r = (i << shamt) truncated to 32 bits; vacated LSBs are zero-filled; bits shifted past bit 31 are discarded.
REQ-011 shamt = 0 passes i through unchanged.
REQ-012 shamt = 31: r[31] = i[0] and r[30:0] = 0.
REQ-013 Datapath is a 5-stage logarithmic barrel shifter; stage k shifts by 2^k when shamt[k] = 1 (k = 0..4) and passes its input through otherwise.
REQ-014 Stage order is 1, 2, 4, 8, 16 (LSB of shamt first); the result is independent of order and the order is fixed for review.
REQ-015 The stages are purely combinational; the only state is the output register (r, out_valid).
REQ-016 Latency: one cycle. If in_valid = 1 at edge N, r = shifted value and out_valid = 1 after edge N.
REQ-017 If in_valid = 0 at an edge, r holds its previous value and out_valid = 0 after that edge.
REQ-018 Back-to-back valid inputs produce one result per cycle; there is no stall and no backpressure input.
REQ-019 shamt bits above the 5-bit port cannot occur; no overflow or error output exists.

Reset
REQ-020 rst_n = 0 at a rising edge sets r = 32'h0000_0000 and out_valid = 0; reset has priority over in_valid.
REQ-021 Reset asserted while an operation is in flight discards that result; the first out_valid after reset follows the first valid input sampled with rst_n = 1.
REQ-022 Reset is not sampled between clock edges; there is no asynchronous path.

Structure
REQ-023 Shared package: DATA_W = 32 and SHAMT_W = 5 constants, plus the data_t (32-bit) and shamt_t (5-bit) typedefs.
REQ-024 One sub-module, mux2_32: a 32-bit 2:1 multiplexer, instantiated once per shift stage (5 instances).
REQ-025 The top level contains the stage wiring, the fixed zero-fill connections, and the output register.

Verification
REQ-026 i = 32'hFFFF_FFFF, shamt = 5, in_valid = 1 -> next cycle r = 32'hFFFF_FFE0, out_valid = 1.
REQ-027 i = 32'hFFFF_FFFF with shamt = 1 / 10 / 16 / 31 on consecutive cycles -> r = 32'hFFFF_FFFE / 32'hFFFF_FC00 / 32'hFFFF_0000 / 32'h8000_0000 on the following consecutive cycles.
REQ-028 i = 32'h1234_5678, shamt = 0 -> r = 32'h1234_5678; i = 32'h0000_0001, shamt = 31 -> r = 32'h8000_0000.
REQ-029 After a valid result, drive in_valid = 0 with a changed i -> r holds its last value, out_valid = 0.
REQ-030 Valid input at edge N with rst_n = 0 at edge N+1 -> r = 0, out_valid = 0 after edge N+1; a valid input after release works normally.
REQ-031 Random i and shamt, 10,000 cycles -> r matches the (i << shamt) reference model delayed by one cycle.

Source files
------------

// File: rtl/shift_left_32bit_pkg.sv
// Shared constants and types for the 32-bit logarithmic left shifter.
package shift_left_32bit_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int NUM_STAGES = SHAMT_W;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/shift_left_32bit_mux2_32.sv
// 32-bit 2:1 multiplexer used as one barrel-shifter stage: y = sel ? b : a.
module mux2_32
  import shift_left_32bit_pkg::*;
(
  input  data_t a,
  input  data_t b,
  input  logic  sel,
  output data_t y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_left_32bit.sv
// Registered 32-bit logical left shifter built from five combinational
// mux stages (shift by 1, 2, 4, 8, 16) feeding a single output register.
module shift_left_32bit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  i,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  r,
  output logic               out_valid
);

  import shift_left_32bit_pkg::*;

  // stage_data[k] is the operand after stages 0..k-1 have been applied
  data_t stage_data [0:SHAMT_W];
  data_t r_reg;
  logic  out_valid_reg;

  assign stage_data[0] = i;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      data_t shifted;

      // Upper bits fall off the top; vacated LSBs are tied to zero
      assign shifted = {stage_data[gi][DATA_W-1-SH:0], {SH{1'b0}}};

      mux2_32 u_mux (
        .a   (stage_data[gi]),
        .b   (shifted),
        .sel (shamt[gi]),
        .y   (stage_data[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        r_reg <= stage_data[SHAMT_W];
      end
    end
  end

  assign r         = r_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_left_32bit.sv
// Directed and random checks of shift_left_32bit against hand-computed values.
module tb_shift_left_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] i;
  logic [4:0]  shamt;
  logic [31:0] r;
  logic        out_valid;

  int checks;
  int errors;

  shift_left_32bit #(
    .DATA_W  (32),
    .SHAMT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .i         (i),
    .shamt     (shamt),
    .r         (r),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then wait past the next rising edge
  task automatic cycle(input logic rst_v, input logic v, input logic [31:0] d, input logic [4:0] s);
    @(negedge clk);
    rst_n    = rst_v;
    in_valid = v;
    i        = d;
    shamt    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_r, input logic exp_v);
    $display("step %-12s rst_n=%b in_valid=%b i=%h shamt=%0d -> r=%h out_valid=%b",
             tag, rst_n, in_valid, i, shamt, r, out_valid);
    check({tag, ".r"}, r, exp_r);
    check({tag, ".v"}, {31'b0, out_valid}, {31'b0, exp_v});
  endtask

  initial begin
    logic [31:0] model_r;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rv;

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    i        = '0;
    shamt    = '0;

    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd3);
    expect_out("reset0", 32'h0000_0000, 1'b0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd1);
    expect_out("reset1", 32'h0000_0000, 1'b0);
    cycle(1'b1, 1'b0, 32'h0000_0000, 5'd0);
    expect_out("idle", 32'h0000_0000, 1'b0);

    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd5);
    expect_out("ones_sh5", 32'hFFFF_FFE0, 1'b1);

    // Back-to-back stream
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd1);
    expect_out("b2b_sh1", 32'hFFFF_FFFE, 1'b1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd10);
    expect_out("b2b_sh10", 32'hFFFF_FC00, 1'b1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd16);
    expect_out("b2b_sh16", 32'hFFFF_0000, 1'b1);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31);
    expect_out("b2b_sh31", 32'h8000_0000, 1'b1);

    cycle(1'b1, 1'b1, 32'h1234_5678, 5'd0);
    expect_out("pass_sh0", 32'h1234_5678, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd31);
    expect_out("one_sh31", 32'h8000_0000, 1'b1);

    // Each stage on its own
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd1);
    expect_out("stage1", 32'h0000_0002, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd2);
    expect_out("stage2", 32'h0000_0004, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd4);
    expect_out("stage4", 32'h0000_0010, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd8);
    expect_out("stage8", 32'h0000_0100, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_ABCD, 5'd16);
    expect_out("stage16", 32'hABCD_0000, 1'b1);
    cycle(1'b1, 1'b1, 32'h8000_0001, 5'd1);
    expect_out("msb_drop", 32'h0000_0002, 1'b1);
    cycle(1'b1, 1'b1, 32'h1234_5678, 5'd13);
    expect_out("mixed13", 32'h8ACF_0000, 1'b1);

    // Hold when not valid
    cycle(1'b1, 1'b0, 32'h5555_5555, 5'd7);
    expect_out("hold0", 32'h8ACF_0000, 1'b0);
    cycle(1'b1, 1'b0, 32'hAAAA_AAAA, 5'd2);
    expect_out("hold1", 32'h8ACF_0000, 1'b0);

    // Reset discards the in-flight result and has priority over in_valid
    cycle(1'b1, 1'b1, 32'h0000_0001, 5'd4);
    expect_out("pre_rst", 32'h0000_0010, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_00FF, 5'd8);
    expect_out("mid_rst", 32'h0000_0000, 1'b0);
    cycle(1'b1, 1'b0, 32'h0000_00FF, 5'd8);
    expect_out("post_rst", 32'h0000_0000, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0003, 5'd2);
    expect_out("after_rst", 32'h0000_000C, 1'b1);

    // Random stream against a one-cycle-delayed shift model
    model_r = 32'h0000_000C;
    for (int n = 0; n < 10000; n++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      rv = ($urandom_range(0, 3) != 0);
      cycle(1'b1, rv, rd, rs);
      if (rv) model_r = rd << rs;
      check("rand.r", r, model_r);
      check("rand.v", {31'b0, out_valid}, {31'b0, rv});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
